// File: rtl/spike_packet_tx.sv
// Timestep spike emitter: snapshots cluster potentials, streams one packet per firing neuron.
// Optional live spike counter built only when SPIKE_TX_COUNT_EN is defined.
module spike_packet_tx #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          timestep_start,
    input  logic [NUM_NEURONS*ADDR_W-1:0] neuron_addresses_initialization,
    input  logic [NUM_NEURONS*32-1:0]     final_potential,
    input  logic [31:0]                   threshold,
    output logic                          spike_valid,
    input  logic                          spike_ready,
    output logic [ADDR_W-1:0]             spike_address,
    output logic [31:0]                   spike_potential,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun,
    output logic [6:0]                    spike_count
);

    // state | meaning
    // IDLE  | waiting for timestep_start; snapshot taken on the pulse
    // SCAN  | evaluating neuron idx against the threshold
    // SEND  | presenting packet for neuron idx until handshake
    // DONE  | one-cycle end-of-scan pulse

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic              snap_en;
    logic              hs;

    logic [ADDR_W-1:0] addr_mem [NUM_NEURONS];
    logic [31:0]       pot_mem  [NUM_NEURONS];
    logic [31:0]       thr_snap;

    logic [31:0]       cur_pot;
    logic              is_nan;
    logic              fire;
    logic              is_last;

    assign cur_pot = pot_mem[idx];
    assign is_nan  = (cur_pot[30:23] == 8'hFF) && (cur_pot[22:0] != 23'd0);
    // Threshold sign is deliberately ignored: magnitude compare on bits 30:0 only.
    assign fire    = !cur_pot[31] && !is_nan && (cur_pot[30:0] >= thr_snap[30:0]);
    assign is_last = (idx == LAST_IDX);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        snap_en   = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (timestep_start) begin
                    snap_en   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (fire) begin
                    state_nxt = SEND;
                end else if (is_last) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            SEND: begin
                if (spike_ready) begin
                    hs = 1'b1;
                    if (is_last) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Neuron 0 sits in the MSBs of both packed vectors.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                addr_mem[i] <= '0;
                pot_mem[i]  <= '0;
            end
            thr_snap <= '0;
        end else if (snap_en) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                addr_mem[i] <= neuron_addresses_initialization[(NUM_NEURONS-1-i)*ADDR_W +: ADDR_W];
                pot_mem[i]  <= final_potential[(NUM_NEURONS-1-i)*32 +: 32];
            end
            thr_snap <= threshold;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (timestep_start && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

`ifdef SPIKE_TX_COUNT_EN
    logic [6:0] count_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count_q <= 7'd0;
        end else if (snap_en) begin
            count_q <= 7'd0;
        end else if (hs) begin
            count_q <= count_q + 7'd1;
        end
    end

    assign spike_count = count_q;
`else
    assign spike_count = 7'd0;
`endif

    assign spike_valid     = (state == SEND);
    assign spike_address   = spike_valid ? addr_mem[idx] : '0;
    assign spike_potential = spike_valid ? cur_pot : 32'd0;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

endmodule

// File: tb/tb_spike_packet_tx.sv
// Scoreboard bench for spike_packet_tx: expected packets queued at stimulus time.
module tb_spike_packet_tx;

    localparam int N  = 10;
    localparam int AW = 12;

    logic            CLK = 1'b0;
    logic            reset;
    logic            timestep_start;
    logic [N*AW-1:0] neuron_addresses_initialization;
    logic [N*32-1:0] final_potential;
    logic [31:0]     threshold;
    logic            spike_valid;
    logic            spike_ready;
    logic [AW-1:0]   spike_address;
    logic [31:0]     spike_potential;
    logic            busy;
    logic            done;
    logic            overrun;
    logic [6:0]      spike_count;

    spike_packet_tx #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .CLK                             (CLK),
        .reset                           (reset),
        .timestep_start                  (timestep_start),
        .neuron_addresses_initialization (neuron_addresses_initialization),
        .final_potential                 (final_potential),
        .threshold                       (threshold),
        .spike_valid                     (spike_valid),
        .spike_ready                     (spike_ready),
        .spike_address                   (spike_address),
        .spike_potential                 (spike_potential),
        .busy                            (busy),
        .done                            (done),
        .overrun                         (overrun),
        .spike_count                     (spike_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   p;
    } pkt_t;

    pkt_t          sb[$];
    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [31:0]   pots     [N];
    logic [AW-1:0] addr_tab [N];
    logic [6:0]    exp_count;

    function automatic logic fires(input logic [31:0] p, input logic [31:0] t);
        logic nan;
        nan = (p[30:23] == 8'hFF) && (p[22:0] != 23'd0);
        return !p[31] && !nan && (p[30:0] >= t[30:0]);
    endfunction

    task automatic set_common();
        pots = '{32'h41deb852, 32'h42806b85, 32'h40b75c29, 32'h4228b852, 32'h42aeb852,
                 32'h429deb85, 32'h4165eb85, 32'h4212147b, 32'h428e2e14, 32'h411a147b};
        for (int i = 0; i < N; i++) addr_tab[i] = AW'(i);
        threshold = 32'h42200000;
    endtask

    // Drives the snapshot inputs, queues the model's expected packets, pulses start.
    task automatic start_scan();
        int fired;
        fired = 0;
        for (int i = 0; i < N; i++) begin
            final_potential[(N-1-i)*32 +: 32]                = pots[i];
            neuron_addresses_initialization[(N-1-i)*AW +: AW] = addr_tab[i];
            if (fires(pots[i], threshold)) begin
                sb.push_back({addr_tab[i], pots[i]});
                fired++;
            end
        end
        exp_count = 7'(fired);
        @(negedge CLK);
        timestep_start = 1'b1;
        @(negedge CLK);
        timestep_start = 1'b0;
    endtask

    task automatic run_scan(input int stall, input int restart_at, input int perturb_at,
                            input int abort_addr, output int busy_cyc, output int done_cyc,
                            output int done_cnt);
        int   stall_left;
        logic in_pkt;
        logic finished;
        pkt_t held;
        pkt_t exp;
        busy_cyc   = 0;
        done_cyc   = -1;
        done_cnt   = 0;
        in_pkt     = 1'b0;
        finished   = 1'b0;
        stall_left = 0;
        held       = '0;
        spike_ready = (stall == 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            timestep_start = (cyc == restart_at);
            if (cyc == perturb_at) begin
                final_potential = {N{32'h42F00000}};
                threshold       = 32'h00000000;
            end
            if (spike_valid) begin
                if (abort_addr >= 0 && spike_address == AW'(abort_addr)) begin
                    reset = 1'b1;
                    #1;
                    tests_run++;
                    if ({spike_valid, spike_address, spike_potential, busy, done, overrun, spike_count}
                        !== '0) begin
                        tests_failed++;
                        $display("FAIL abort_outputs: got valid=%b addr=%h pot=%h busy=%b done=%b ovr=%b cnt=%0d, required all zero",
                                 spike_valid, spike_address, spike_potential, busy, done, overrun, spike_count);
                    end
                    @(negedge CLK);
                    reset = 1'b0;
                    sb.delete();
                    spike_ready = 1'b1;
                    return;
                end
                if (!in_pkt) begin
                    in_pkt     = 1'b1;
                    held       = {spike_address, spike_potential};
                    stall_left = stall;
                end else begin
                    tests_run++;
                    if ({spike_address, spike_potential} !== held) begin
                        tests_failed++;
                        $display("FAIL stall_stable: got %h/%h, required %h/%h",
                                 spike_address, spike_potential, held.a, held.p);
                    end
                end
                if (stall_left > 0) begin
                    spike_ready = 1'b0;
                    stall_left--;
                end else begin
                    spike_ready = 1'b1;
                    in_pkt      = 1'b0;
                    tests_run++;
                    if (sb.size() == 0) begin
                        tests_failed++;
                        $display("FAIL packet_extra: got addr=%h pot=%h, required no packet",
                                 spike_address, spike_potential);
                    end else begin
                        exp = sb.pop_front();
                        if ({spike_address, spike_potential} !== exp) begin
                            tests_failed++;
                            $display("FAIL packet: got addr=%h pot=%h, required addr=%h pot=%h",
                                     spike_address, spike_potential, exp.a, exp.p);
                        end
                    end
                end
            end else if (stall != 0) begin
                spike_ready = 1'b0;
            end
            if (done_cyc >= 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        timestep_start = 1'b0;
        tests_run++;
        if (!finished) begin
            tests_failed++;
            $display("FAIL scan_timeout: got busy=%b after 400 cycles, required return to idle", busy);
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL packets_missing: got %0d left in queue, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_count(input string name);
        logic [6:0] req;
`ifdef SPIKE_TX_COUNT_EN
        req = exp_count;
`else
        req = 7'd0;
`endif
        tests_run++;
        if (spike_count !== req) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d, required %0d", name, spike_count, req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        timestep_start = 1'b0;
        spike_ready = 1'b1;
        neuron_addresses_initialization = '0;
        final_potential = '0;
        threshold = '0;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        tests_run++;
        if ({spike_valid, spike_address, spike_potential, busy, done, overrun, spike_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: got valid=%b addr=%h pot=%h busy=%b done=%b ovr=%b cnt=%0d, required all zero",
                     spike_valid, spike_address, spike_potential, busy, done, overrun, spike_count);
        end
    endtask

    int base_busy;

    task automatic test_basic();
        int bc, dc, dn;
        set_common();
        start_scan();
        run_scan(0, -1, -1, -1, bc, dc, dn);
        base_busy = bc;
        tests_run++;
        if (bc !== 16) begin
            tests_failed++;
            $display("FAIL basic_busy: got %0d cycles, required 16", bc);
        end
        tests_run++;
        if (dn !== 1 || dc !== 15) begin
            tests_failed++;
            $display("FAIL basic_done: got %0d pulses at cycle %0d, required 1 at cycle 15", dn, dc);
        end
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_overrun: got %b, required 0", overrun);
        end
        check_count("basic");
    endtask

    task automatic test_stall();
        int bc, dc, dn;
        set_common();
        start_scan();
        run_scan(3, -1, -1, -1, bc, dc, dn);
        tests_run++;
        if (bc !== base_busy + 15) begin
            tests_failed++;
            $display("FAIL stall_busy: got %0d cycles, required %0d", bc, base_busy + 15);
        end
        check_count("stall");
    endtask

    task automatic test_no_spike();
        int bc, dc, dn;
        set_common();
        for (int i = 0; i < N; i++) pots[i] = (i % 2 == 0) ? 32'hC2200000 : 32'h7fc00000;
        start_scan();
        run_scan(0, -1, -1, -1, bc, dc, dn);
        tests_run++;
        if (dc !== 10 || dn !== 1) begin
            tests_failed++;
            $display("FAIL nospike_done: got %0d pulses first at cycle %0d, required 1 at cycle 10", dn, dc);
        end
        check_count("nospike");
    endtask

    // Equality fires, negative threshold treated as its magnitude, +inf fires, NaN/-0/negatives do not.
    task automatic test_boundary();
        int bc, dc, dn;
        pots = '{32'h42200000, 32'h421FFFFF, 32'h7F800000, 32'h7F800001, 32'hFF800000,
                 32'h80000000, 32'h00000000, 32'h42200001, 32'hC2C80000, 32'h7F7FFFFF};
        for (int i = 0; i < N; i++) addr_tab[i] = AW'(12'hA00 + i * 17);
        threshold = 32'hC2200000;
        start_scan();
        run_scan(1, -1, -1, -1, bc, dc, dn);
        check_count("boundary");
    endtask

    task automatic test_overrun();
        int bc, dc, dn;
        set_common();
        start_scan();
        run_scan(0, 2, 4, -1, bc, dc, dn);
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_flag: got %b, required 1", overrun);
        end
        tests_run++;
        if (bc !== 16) begin
            tests_failed++;
            $display("FAIL overrun_busy: got %0d cycles, required 16", bc);
        end
    endtask

    task automatic test_reset_mid_send();
        int bc, dc, dn;
        set_common();
        start_scan();
        run_scan(2, -1, -1, 4, bc, dc, dn);
        set_common();
        start_scan();
        run_scan(0, -1, -1, -1, bc, dc, dn);
        tests_run++;
        if (bc !== 16 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset: got busy=%0d ovr=%b, required busy=16 ovr=0", bc, overrun);
        end
        check_count("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_no_spike();
        test_boundary();
        test_overrun();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
